// File: rtl/mon_i2c_sync_fifo.sv
// I2C bus monitor: synchronises SCL/SDA, decodes S/P/0/1 events into a DEPTH-entry valid/ready FIFO.
// Minimum-timing checks are built only when MON_I2C_SYNC_TIMING_CHECK_EN is defined.
module mon_i2c_sync_fifo #(
  parameter int         DEPTH       = 16,
  parameter int         CNT_W       = 16,
  parameter int         SYNC_STAGES = 2,
  parameter logic [1:0] EVT_0       = 2'b00,
  parameter logic [1:0] EVT_1       = 2'b01,
  parameter logic [1:0] EVT_P       = 2'b10,
  parameter logic [1:0] EVT_S       = 2'b11
) (
  input  logic                     i_clk,
  input  logic                     i_clr_all,
  input  logic                     i_scl,
  input  logic                     i_sda,
  input  logic                     i_en_timing_check,
  input  logic [CNT_W-1:0]         i_t_low,
  input  logic [CNT_W-1:0]         i_t_su,
  output logic                     o_evt_valid,
  output logic [1:0]               o_evt,
  input  logic                     i_evt_ready,
  output logic [$clog2(DEPTH):0]   o_fifo_level,
  output logic                     o_overflow,
  output logic [31:0]              o_num_events,
  output logic                     o_busy,
  output logic                     o_timing_check_err,
  output logic [1:0]               o_err_code
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl, sda, scl_d, sda_d;

  always_ff @(posedge i_clk or posedge i_clr_all) begin
    if (i_clr_all) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], i_scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], i_sda};
      scl_d    <= scl;
      sda_d    <= sda;
    end
  end

  assign scl = scl_sync[SYNC_STAGES-1];
  assign sda = sda_sync[SYNC_STAGES-1];

  logic scl_rise, scl_fall, scl_hi, sda_rise, sda_fall;
  assign scl_rise = scl & ~scl_d;
  assign scl_fall = ~scl & scl_d;
  assign scl_hi   = scl & scl_d;
  assign sda_rise = sda & ~sda_d;
  assign sda_fall = ~sda & sda_d;

  logic       psbl_data;
  logic       dec_vld;
  logic [1:0] dec_evt;

  // The data bit is the SDA value seen while SCL was still high, hence sda_d.
  always_comb begin
    dec_vld = 1'b0;
    dec_evt = EVT_0;
    if (scl_fall && psbl_data) begin
      dec_vld = 1'b1;
      dec_evt = sda_d ? EVT_1 : EVT_0;
    end else if (scl_hi && sda_fall) begin
      dec_vld = 1'b1;
      dec_evt = EVT_S;
    end else if (scl_hi && sda_rise) begin
      dec_vld = 1'b1;
      dec_evt = EVT_P;
    end
  end

  logic       evt_vld;
  logic [1:0] evt_q;

  always_ff @(posedge i_clk or posedge i_clr_all) begin
    if (i_clr_all) begin
      psbl_data <= 1'b0;
      evt_vld   <= 1'b0;
      evt_q     <= EVT_0;
      o_busy    <= 1'b0;
    end else begin
      if (scl_rise)
        psbl_data <= 1'b1;
      else if (scl_hi && (sda_rise || sda_fall))
        psbl_data <= 1'b0;
      evt_vld <= dec_vld;
      evt_q   <= dec_evt;
      if (scl_hi && sda_fall)
        o_busy <= 1'b1;
      else if (scl_hi && sda_rise)
        o_busy <= 1'b0;
    end
  end

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop, wr_en, full;

  assign full        = (o_fifo_level == FULL_LVL);
  assign o_evt_valid = (o_fifo_level != '0);
  assign pop         = o_evt_valid & i_evt_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en       = evt_vld & (pop | ~full);
  assign o_evt       = o_evt_valid ? mem[rd_ptr] : 2'b00;

  always_ff @(posedge i_clk) begin
    if (wr_en)
      mem[wr_ptr] <= evt_q;
  end

  always_ff @(posedge i_clk or posedge i_clr_all) begin
    if (i_clr_all) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_fifo_level <= '0;
      o_overflow   <= 1'b0;
      o_num_events <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)
        o_fifo_level <= o_fifo_level + 1'b1;
      else if (!wr_en && pop)
        o_fifo_level <= o_fifo_level - 1'b1;
      if (evt_vld && !wr_en)
        o_overflow <= 1'b1;
      if (evt_vld && (o_num_events != 32'hFFFF_FFFF))
        o_num_events <= o_num_events + 32'd1;
    end
  end

`ifdef MON_I2C_SYNC_TIMING_CHECK_EN
  logic [CNT_W-1:0] cnt_low, cnt_su;
  logic low_edge, su_edge, low_viol, su_viol;

  assign low_edge = scl_rise | scl_fall | (scl_hi & (sda_rise | sda_fall));
  assign su_edge  = ~scl & (sda_rise | sda_fall);
  assign low_viol = i_en_timing_check & low_edge & (cnt_low < i_t_low);
  assign su_viol  = i_en_timing_check & scl_rise & (cnt_su < i_t_su);

  // Counters start saturated so the first edge after reset never violates.
  always_ff @(posedge i_clk or posedge i_clr_all) begin
    if (i_clr_all) begin
      cnt_low            <= '1;
      cnt_su             <= '1;
      o_timing_check_err <= 1'b0;
      o_err_code         <= 2'd0;
    end else begin
      if (low_edge)
        cnt_low <= '0;
      else if (cnt_low != '1)
        cnt_low <= cnt_low + 1'b1;
      if (su_edge)
        cnt_su <= '0;
      else if (cnt_su != '1)
        cnt_su <= cnt_su + 1'b1;
      if (low_viol || su_viol)
        o_timing_check_err <= 1'b1;
      if (su_viol)
        o_err_code <= 2'd2;
      else if (low_viol)
        o_err_code <= 2'd1;
      if (low_viol)
        $display("mon_i2c_sync_fifo: t=%0t timing violation code 1 (T_LOW) count %0d", $time, cnt_low);
      if (su_viol)
        $display("mon_i2c_sync_fifo: t=%0t timing violation code 2 (T_SU) count %0d", $time, cnt_su);
    end
  end
`else
  logic unused_timing;
  assign unused_timing      = ^{i_en_timing_check, i_t_low, i_t_su};
  assign o_timing_check_err = 1'b0;
  assign o_err_code         = 2'd0;
`endif

endmodule
